// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch flush, EX/MEM/WB forwarding selects
// and saturating stall/flush event counters for the 5-stage pipeline.
module hazard_stall_controller #(
   parameter int REG_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             R,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_rn_used,
   input  logic             id_rm_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_rf_enable,
   input  logic             id_load_instr,
   input  logic             ex_branch_taken,
   output logic             LE,
   output logic             S,
   output logic             flush_if,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RST = 2'b00, RUN = 2'b01, STALL = 2'b10, FLUSH = 2'b11} state_t;
   typedef struct packed {
      logic             rf_en;
      logic             load;
      logic [REG_W-1:0] rd;
   } tag_t;
   localparam logic [REG_W-1:0] PC_REG = '1;
   state_t cur, nxt;
   tag_t ex_tag, mem_tag, wb_tag;
   logic in_rst, rn_hit, rm_hit, load_use;

   // A load still in EX has no data yet; the stall covers it, so report regfile.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                          input tag_t ex, input tag_t mem, input tag_t wb);
      if (!used || src == PC_REG) return 2'b00;
      if (ex.rf_en && ex.rd == src) return ex.load ? 2'b00 : 2'b01;
      if (mem.rf_en && mem.rd == src) return 2'b10;
      if (wb.rf_en && wb.rd == src) return 2'b11;
      return 2'b00;
   endfunction

   always_comb begin
      in_rst   = (cur == RST);
      rn_hit   = id_rn_used && (id_rn == ex_tag.rd);
      rm_hit   = id_rm_used && (id_rm == ex_tag.rd);
      load_use = !in_rst && ex_tag.load && ex_tag.rf_en && (rn_hit || rm_hit);
      LE       = !in_rst && (ex_branch_taken || !load_use);
      S        = in_rst || ex_branch_taken || load_use;
      flush_if = !in_rst && ex_branch_taken;
      fwd_a    = in_rst ? 2'b00 : fwd_sel(id_rn_used, id_rn, ex_tag, mem_tag, wb_tag);
      fwd_b    = in_rst ? 2'b00 : fwd_sel(id_rm_used, id_rm, ex_tag, mem_tag, wb_tag);
      nxt      = in_rst ? RUN : ex_branch_taken ? FLUSH : load_use ? STALL : RUN;
   end

   assign state = cur;

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         cur       <= RST;
         ex_tag    <= '0;
         mem_tag   <= '0;
         wb_tag    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         cur <= nxt;
         if (!in_rst) begin
            ex_tag  <= S ? '0 : {id_rf_enable, id_load_instr, id_rd};
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
         end
         if (nxt == STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (nxt == FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed scenarios with hand-computed expectations.
module tb_hazard_stall_controller;
   localparam int REG_W = 4;
   localparam int CNT_W = 8;
   logic clk = 1'b0;
   logic R = 1'b0;
   logic [REG_W-1:0] id_rn, id_rm, id_rd;
   logic id_rn_used, id_rm_used, id_rf_enable, id_load_instr, ex_branch_taken;
   logic LE, S, flush_if;
   logic [1:0] fwd_a, fwd_b, state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .R(R), .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used),
      .id_rm_used(id_rm_used), .id_rd(id_rd), .id_rf_enable(id_rf_enable),
      .id_load_instr(id_load_instr), .ex_branch_taken(ex_branch_taken), .LE(LE), .S(S),
      .flush_if(flush_if), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic set_id(input logic [3:0] rd, input logic rf, input logic ld,
                         input logic [3:0] rn, input logic rn_u,
                         input logic [3:0] rm, input logic rm_u, input logic br);
      id_rd = rd; id_rf_enable = rf; id_load_instr = ld;
      id_rn = rn; id_rn_used = rn_u; id_rm = rm; id_rm_used = rm_u;
      ex_branch_taken = br;
   endtask

   task automatic idle();
      set_id(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      #1;
      if ({LE, S, flush_if, state} !== 5'b01000) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", {LE, S, flush_if, state}, 5'b01000); end
      checks++;
      if ({fwd_a, fwd_b, stall_cnt, flush_cnt} !== 20'h0) begin errors++; $display("FAIL reset_fwd_cnt: got %h expected %h", {fwd_a, fwd_b, stall_cnt, flush_cnt}, 20'h0); end
      checks++;
      #2 R = 1'b1;
      tick();
      if ({LE, S, flush_if, state} !== 5'b10001) begin errors++; $display("FAIL reset_release: got %b expected %b", {LE, S, flush_if, state}, 5'b10001); end
      checks++;
      if ({stall_cnt, flush_cnt} !== 16'h0) begin errors++; $display("FAIL reset_counters: got %h expected %h", {stall_cnt, flush_cnt}, 16'h0); end
      checks++;
   endtask

   task automatic test_alu_forwarding();
      set_id(4'd1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
      #1;
      if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL alu_first: got %b expected %b", {fwd_a, fwd_b}, 4'b0000); end
      checks++;
      tick();
      set_id(4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1, 1'b0);
      #1;
      if ({fwd_a, fwd_b, LE, S} !== 6'b010010) begin errors++; $display("FAIL alu_fwd_ex: got %b expected %b", {fwd_a, fwd_b, LE, S}, 6'b010010); end
      checks++;
      tick();
      set_id(4'd7, 1'b1, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1, 1'b0);
      #1;
      if ({fwd_a, fwd_b} !== 4'b1000) begin errors++; $display("FAIL alu_fwd_mem: got %b expected %b", {fwd_a, fwd_b}, 4'b1000); end
      checks++;
      tick();
      set_id(4'd8, 1'b0, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
      #1;
      if ({fwd_a, fwd_b} !== 4'b1110) begin errors++; $display("FAIL alu_fwd_wb: got %b expected %b", {fwd_a, fwd_b}, 4'b1110); end
      checks++;
      tick();
      set_id(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      set_id(4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      set_id(4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd1, 1'b0, 1'b0);
      #1;
      if ({fwd_a, fwd_b} !== 4'b0100) begin errors++; $display("FAIL alu_ex_priority: got %b expected %b", {fwd_a, fwd_b}, 4'b0100); end
      checks++;
      idle();
      repeat (3) tick();
   endtask

   task automatic test_load_use();
      set_id(4'd4, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
      #1;
      if ({LE, S, flush_if} !== 3'b100) begin errors++; $display("FAIL ldr_issue: got %b expected %b", {LE, S, flush_if}, 3'b100); end
      checks++;
      tick();
      set_id(4'd5, 1'b1, 1'b0, 4'd6, 1'b1, 4'd4, 1'b1, 1'b0);
      #1;
      if ({LE, S, flush_if, state, fwd_b} !== 7'b0100100) begin errors++; $display("FAIL lu_stall: got %b expected %b", {LE, S, flush_if, state, fwd_b}, 7'b0100100); end
      checks++;
      tick();
      if ({state, stall_cnt} !== {2'b10, 8'd1}) begin errors++; $display("FAIL lu_state: got %h expected %h", {state, stall_cnt}, {2'b10, 8'd1}); end
      checks++;
      if ({LE, S, fwd_a, fwd_b} !== 6'b100010) begin errors++; $display("FAIL lu_after_bubble: got %b expected %b", {LE, S, fwd_a, fwd_b}, 6'b100010); end
      checks++;
      tick();
      if ({state, stall_cnt} !== {2'b01, 8'd1}) begin errors++; $display("FAIL lu_resume: got %h expected %h", {state, stall_cnt}, {2'b01, 8'd1}); end
      checks++;
      idle();
      repeat (3) tick();
   endtask

   task automatic test_branch_flush();
      set_id(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      #1;
      if ({LE, S, flush_if} !== 3'b111) begin errors++; $display("FAIL br_outputs: got %b expected %b", {LE, S, flush_if}, 3'b111); end
      checks++;
      tick();
      if ({state, flush_cnt, stall_cnt} !== {2'b11, 8'd1, 8'd1}) begin errors++; $display("FAIL br_state: got %h expected %h", {state, flush_cnt, stall_cnt}, {2'b11, 8'd1, 8'd1}); end
      checks++;
      idle();
      #1;
      if ({LE, S, flush_if} !== 3'b100) begin errors++; $display("FAIL br_release: got %b expected %b", {LE, S, flush_if}, 3'b100); end
      checks++;
      tick();
      if (state !== 2'b01) begin errors++; $display("FAIL br_back_run: got %b expected %b", state, 2'b01); end
      checks++;
   endtask

   task automatic test_branch_and_load_use();
      set_id(4'd4, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
      tick();
      set_id(4'd5, 1'b1, 1'b0, 4'd6, 1'b1, 4'd4, 1'b1, 1'b1);
      #1;
      if ({LE, S, flush_if} !== 3'b111) begin errors++; $display("FAIL brlu_outputs: got %b expected %b", {LE, S, flush_if}, 3'b111); end
      checks++;
      tick();
      if ({state, flush_cnt, stall_cnt} !== {2'b11, 8'd2, 8'd1}) begin errors++; $display("FAIL brlu_counts: got %h expected %h", {state, flush_cnt, stall_cnt}, {2'b11, 8'd2, 8'd1}); end
      checks++;
      idle();
      tick();
      if (state !== 2'b01) begin errors++; $display("FAIL brlu_back_run: got %b expected %b", state, 2'b01); end
      checks++;
      repeat (2) tick();
   endtask

   task automatic test_r15();
      set_id(4'd15, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
      tick();
      set_id(4'd0, 1'b0, 1'b0, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
      #1;
      if ({fwd_a, fwd_b, LE, S} !== 6'b000010) begin errors++; $display("FAIL r15_fwd: got %b expected %b", {fwd_a, fwd_b, LE, S}, 6'b000010); end
      checks++;
      tick();
      idle();
      repeat (2) tick();
   endtask

   task automatic test_saturation_and_async_reset();
      for (int i = 0; i < 300; i++) begin
         set_id(4'd4, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
         tick();
         set_id(4'd5, 1'b1, 1'b0, 4'd6, 1'b1, 4'd4, 1'b1, 1'b0);
         tick();
         if (i == 252) begin
            if (stall_cnt !== 8'd254) begin errors++; $display("FAIL sat_before: got %0d expected %0d", stall_cnt, 254); end
            checks++;
         end
      end
      if ({state, stall_cnt, flush_cnt} !== {2'b10, 8'd255, 8'd2}) begin errors++; $display("FAIL sat_final: got %h expected %h", {state, stall_cnt, flush_cnt}, {2'b10, 8'd255, 8'd2}); end
      checks++;
      R = 1'b0;
      #1;
      if ({LE, S, flush_if, state, fwd_a, fwd_b} !== 9'b010000000) begin errors++; $display("FAIL async_rst_ctrl: got %b expected %b", {LE, S, flush_if, state, fwd_a, fwd_b}, 9'b010000000); end
      checks++;
      if ({stall_cnt, flush_cnt} !== 16'h0) begin errors++; $display("FAIL async_rst_cnt: got %h expected %h", {stall_cnt, flush_cnt}, 16'h0); end
      checks++;
      R = 1'b1;
      tick();
      if ({state, LE, S, stall_cnt} !== {2'b01, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL post_rst_run: got %h expected %h", {state, LE, S, stall_cnt}, {2'b01, 1'b1, 1'b0, 8'd0}); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_alu_forwarding();
      test_load_use();
      test_branch_flush();
      test_branch_and_load_use();
      test_r15();
      test_saturation_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
